cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the M stage; sits directly upstream of the EPC register and drives its write ports (PC capture and mtc0 write).
- Holds SR and Cause.
- Arbitrates hardware interrupts against synchronous exceptions, and sequences entry, handler residence and eret return.
- Drives the pipeline flush/redirect request and the mfc0 read mux.

Parameters:
- HANDLER_PC, 32'h0000_4180, redirect target on exception/interrupt entry.
- PRID_VAL, 32'h0000_0000, constant value returned for PRId (reg 15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- pc_m  in  32  PC of the instruction in M.
- bd_m  in  1  M instruction is in a branch delay slot.
- exc_valid_m  in  1  M instruction raised a synchronous exception.
- exc_code_m  in  5  ExcCode for exc_valid_m.
- hw_int  in  6  device interrupt lines, level-sensitive.
- eret_m  in  1  eret in M.
- cp0_we  in  1  mtc0 in M.
- cp0_addr  in  5  CP0 register number.
- cp0_wdata  in  32  mtc0 data.
- epc_dout  in  32  current EPC value.
- epc_pcwe  out  1  EPC PC-capture enable.
- epc_pc_in  out  32  value to capture into EPC.
- epc_we  out  1  EPC mtc0 write enable.
- epc_din  out  32  mtc0 data to EPC.
- cp0_rdata  out  32  mfc0 read data.
- exc_req  out  1  flush pipeline and redirect to HANDLER_PC.
- eret_req  out  1  redirect to epc_dout.
- exl  out  1  SR.EXL.

Behaviour:
- Reset (async): SR = 0 (IM=0, EXL=0, IE=0); Cause = 0; state = NORMAL.
  - All combinational outputs follow from the reset state: exc_req = 0, eret_req = 0, epc_pcwe = 0, epc_we = 0.
- SR fields (reg 12): IM = SR[15:10], EXL = SR[1], IE = SR[0]. All other SR bits read 0 and ignore writes.
- Cause fields (reg 13):
  - BD = Cause[31].
  - IP = Cause[15:10]: read-only, registered every cycle from hw_int.
  - ExcCode = Cause[6:2].
  - All other bits read 0.
- int_take = |(hw_int & IM) & IE & ~EXL & (state != GUARD). Uses the live hw_int, not the registered IP.
- exc_take = exc_valid_m & ~EXL & ~int_take. Interrupt has priority over exception. Exceptions raised while EXL=1 are ignored (no nesting).
- take = int_take | exc_take. It is combinational, same cycle as M.
  - exc_req = take.
  - epc_pcwe = take.
  - epc_pc_in = (bd_m ? pc_m - 4 : pc_m) with bits [1:0] forced to 0.
- On the clock edge where take = 1:
  - EXL <= 1.
  - BD <= bd_m.
  - ExcCode <= int_take ? 0 : exc_code_m.
  - state <= HANDLER.
- eret_req = eret_m & EXL & ~take. On that edge: EXL <= 0, state <= GUARD.
- State machine:
  - NORMAL --take--> HANDLER.
  - HANDLER --eret_req--> GUARD.
  - GUARD --unconditional, 1 cycle--> NORMAL.
  - GUARD blocks interrupts for one cycle so at least one instruction at EPC retires. Synchronous exceptions in GUARD are still taken.
  - state == HANDLER iff EXL = 1, except when mtc0 writes EXL directly: a direct write sets state to HANDLER (EXL=1) or NORMAL (EXL=0).
- mtc0 (cp0_we & ~take):
  - addr 12: writes IM/EXL/IE.
  - addr 13: writes only ExcCode and BD.
  - addr 14: epc_we = 1, epc_din = cp0_wdata.
  - Any other addr: ignored.
  - When take = 1 in the same cycle, the mtc0 is suppressed entirely (epc_we = 0). Exception capture always wins over mtc0 for EPC.
- mfc0: cp0_rdata is combinational.
  - 12: SR.
  - 13: Cause.
  - 14: epc_dout.
  - 15: PRID_VAL.
  - Any other addr: 0.
- eret_m while EXL = 0: no redirect, no state change.
- Reset asserted mid-handler returns to NORMAL immediately, independent of clk.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined:
  - Adds Count (reg 9, +1 every cycle, wraps 32'hFFFF_FFFF -> 0) and Compare (reg 11), both reset to 0.
  - A timer pending flag sets when Count == Compare and Compare != 0.
  - A write to Compare clears the flag.
  - The flag is ORed into hw_int[5] before IP/int_take.
  - mtc0 to 9 loads Count. mfc0 reads both registers.
- Not defined: regs 9 and 11 read 0 and ignore writes; hw_int[5] is used unmodified.

Test Plan:
- SR = 32'h0000_0401, hw_int = 6'b000001, pc_m = 32'h0000_3010, bd_m = 0 -> exc_req = 1, epc_pc_in = 32'h0000_3010, next-cycle EXL = 1, ExcCode = 0, Cause.IP = 6'b000001.
- exc_valid_m = 1, exc_code_m = 5'd12, bd_m = 1, pc_m = 32'h0000_3024, EXL = 0 -> epc_pc_in = 32'h0000_3020, BD = 1, ExcCode = 12, exc_req = 1.
- Interrupt and exception in the same cycle (IE = 1, IM[0] = 1, hw_int[0] = 1, exc_code_m = 4) -> ExcCode = 0 (interrupt wins); epc_pcwe asserted once.
- In HANDLER, eret_m = 1 with hw_int still asserted -> eret_req = 1, next cycle GUARD with exc_req = 0, following cycle exc_req = 1.
- mtc0 addr 14, cp0_wdata = 32'h0000_3100 while an exception is taken in the same cycle -> epc_we = 0, epc_pcwe = 1; mtc0 addr 14 with no exception -> epc_we = 1, epc_din = 32'h0000_3100.
- CP0_TIMER_EN defined, Compare = 5, SR = 32'h0000_8001 -> exc_req asserts once Count = 5 is reached; async reset asserted mid-handler -> SR = 0, Cause = 0, exl = 0 without waiting for a clk edge.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller for the M stage.
// Holds SR and Cause, arbitrates interrupts against synchronous exceptions,
// sequences entry / handler residence / eret return, drives EPC write ports,
// the flush/redirect requests and the mfc0 read mux.
// Optional Count/Compare timer enabled with CP0_TIMER_EN.
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        exc_valid_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hw_int,
  input  logic        eret_m,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [31:0] epc_dout,
  output logic        epc_pcwe,
  output logic [31:0] epc_pc_in,
  output logic        epc_we,
  output logic [31:0] epc_din,
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic        eret_req,
  output logic        exl
);

  typedef enum logic [1:0] {NORMAL, HANDLER, GUARD} state_t;

  state_t      state, state_nxt;
  logic [5:0]  im, ip, hw_eff;
  logic        exl_q, ie, bd;
  logic [4:0]  exc_code;
  logic        int_take, exc_take, take, wr, sr_wr, cause_wr;
  logic [31:0] sr, cause, pc_adj;

  // Redirect target is consumed by the fetch stage; kept here as config only.
  logic unused_cfg;
  assign unused_cfg = ^HANDLER_PC;

  assign exl   = exl_q;
  assign sr    = {16'b0, im, 8'b0, exl_q, ie};
  assign cause = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        tmr_pend;

  // Free-running Count, Compare register and sticky match flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      compare  <= '0;
      tmr_pend <= 1'b0;
    end else begin
      count <= (wr && cp0_addr == 5'd9) ? cp0_wdata : count + 32'd1;
      if (wr && cp0_addr == 5'd11) begin
        compare  <= cp0_wdata;
        tmr_pend <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        tmr_pend <= 1'b1;
      end
    end
  end

  assign hw_eff = {hw_int[5] | tmr_pend, hw_int[4:0]};
`else
  assign hw_eff = hw_int;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= NORMAL;
    else       state <= state_nxt;
  end

  // Next state: entry beats eret, eret beats a direct EXL write
  always_comb begin
    state_nxt = state;
    if (take)               state_nxt = HANDLER;
    else if (eret_req)      state_nxt = GUARD;
    else if (sr_wr)         state_nxt = cp0_wdata[1] ? HANDLER : NORMAL;
    else if (state == GUARD) state_nxt = NORMAL;
  end

  // Arbitration, redirect requests, EPC ports and mfc0 mux
  always_comb begin
    int_take  = (|(hw_eff & im)) & ie & ~exl_q & (state != GUARD);
    exc_take  = exc_valid_m & ~exl_q & ~int_take;
    take      = int_take | exc_take;
    exc_req   = take;
    epc_pcwe  = take;
    pc_adj    = bd_m ? pc_m - 32'd4 : pc_m;
    epc_pc_in = {pc_adj[31:2], 2'b00};
    eret_req  = eret_m & exl_q & ~take;
    wr        = cp0_we & ~take;
    sr_wr     = wr & (cp0_addr == 5'd12);
    cause_wr  = wr & (cp0_addr == 5'd13);
    epc_we    = wr & (cp0_addr == 5'd14);
    epc_din   = cp0_wdata;
    case (cp0_addr)
`ifdef CP0_TIMER_EN
      5'd9:    cp0_rdata = count;
      5'd11:   cp0_rdata = compare;
`endif
      5'd12:   cp0_rdata = sr;
      5'd13:   cp0_rdata = cause;
      5'd14:   cp0_rdata = epc_dout;
      5'd15:   cp0_rdata = PRID_VAL;
      default: cp0_rdata = 32'd0;
    endcase
  end

  // SR / Cause update: exception entry overrides mtc0 on shared fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= '0;
      exl_q    <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
    end else begin
      ip <= hw_eff;
      if (sr_wr) begin
        im <= cp0_wdata[15:10];
        ie <= cp0_wdata[0];
      end
      if (cause_wr) begin
        bd       <= cp0_wdata[31];
        exc_code <= cp0_wdata[6:2];
      end
      if (take) begin
        exl_q    <= 1'b1;
        bd       <= bd_m;
        exc_code <= int_take ? 5'd0 : exc_code_m;
      end else if (eret_req) begin
        exl_q <= 1'b0;
      end else if (sr_wr) begin
        exl_q <= cp0_wdata[1];
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed table-driven bench for cp0_exc_ctrl, plus hand sequences for
// async reset mid-handler and the Count/Compare timer (or its absence).
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h0001_9300;
  localparam logic [31:0] EPCD = 32'hBFC0_0180;

  logic        clk = 0, reset = 1;
  logic [31:0] pc_m = 0, cp0_wdata = 0, epc_dout = EPCD;
  logic        bd_m = 0, exc_valid_m = 0, eret_m = 0, cp0_we = 0;
  logic [4:0]  exc_code_m = 0, cp0_addr = 0;
  logic [5:0]  hw_int = 0;
  logic        epc_pcwe, epc_we, exc_req, eret_req, exl;
  logic [31:0] epc_pc_in, epc_din, cp0_rdata;

  int total = 0, passed = 0;

  cp0_exc_ctrl #(.HANDLER_PC(32'h0000_4180), .PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m),
    .exc_valid_m(exc_valid_m), .exc_code_m(exc_code_m), .hw_int(hw_int),
    .eret_m(eret_m), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .epc_dout(epc_dout), .epc_pcwe(epc_pcwe),
    .epc_pc_in(epc_pc_in), .epc_we(epc_we), .epc_din(epc_din),
    .cp0_rdata(cp0_rdata), .exc_req(exc_req), .eret_req(eret_req), .exl(exl));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc; logic bd, ev; logic [4:0] code; logic [5:0] hw;
    logic eret, we; logic [4:0] addr; logic [31:0] wdata;
    logic x_exc, x_eret; logic [31:0] x_pcin; logic x_we;
    logic [31:0] x_rd; logic x_exl;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(logic [31:0] pc, logic bd, logic ev, logic [4:0] code,
      logic [5:0] hw, logic eret, logic we, logic [4:0] addr, logic [31:0] wdata,
      logic x_exc, logic x_eret, logic [31:0] x_pcin, logic x_we,
      logic [31:0] x_rd, logic x_exl);
    vec_t v;
    v.pc = pc; v.bd = bd; v.ev = ev; v.code = code; v.hw = hw; v.eret = eret;
    v.we = we; v.addr = addr; v.wdata = wdata; v.x_exc = x_exc; v.x_eret = x_eret;
    v.x_pcin = x_pcin; v.x_we = x_we; v.x_rd = x_rd; v.x_exl = x_exl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    pc_m = v.pc; bd_m = v.bd; exc_valid_m = v.ev; exc_code_m = v.code;
    hw_int = v.hw; eret_m = v.eret; cp0_we = v.we; cp0_addr = v.addr;
    cp0_wdata = v.wdata;
  endtask

  task automatic idle(input logic [4:0] addr);
    pc_m = 0; bd_m = 0; exc_valid_m = 0; exc_code_m = 0; hw_int = 0;
    eret_m = 0; cp0_we = 0; cp0_addr = addr; cp0_wdata = 0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] d);
    @(negedge clk);
    idle(addr); cp0_we = 1; cp0_wdata = d;
  endtask

  initial begin
    bit fired;
    //              pc       bd ev code hw    er we ad  wdata          exc er pcin     we rdata          exl
    tbl[0]  = mk(0,          0,0,0,  6'h00,0,1,12,32'h0000_0401, 0,0,0,          0,32'h0,          0);
    tbl[1]  = mk(0,          0,0,0,  6'h00,0,0,12,0,             0,0,0,          0,32'h401,        0);
    tbl[2]  = mk(32'h3010,   0,0,0,  6'h01,0,0,13,0,             1,0,32'h3010,   0,32'h0,          0);
    tbl[3]  = mk(0,          0,0,0,  6'h01,0,0,13,0,             0,0,0,          0,32'h400,        1);
    tbl[4]  = mk(0,          0,0,0,  6'h01,1,0,12,0,             0,1,0,          0,32'h403,        1);
    tbl[5]  = mk(0,          0,0,0,  6'h01,0,0,12,0,             0,0,0,          0,32'h401,        0);
    tbl[6]  = mk(32'h3040,   0,0,0,  6'h01,0,0,12,0,             1,0,32'h3040,   0,32'h401,        0);
    tbl[7]  = mk(0,          0,0,0,  6'h00,1,0,13,0,             0,1,0,          0,32'h400,        1);
    tbl[8]  = mk(32'h3024,   1,1,12, 6'h00,0,0,13,0,             1,0,32'h3020,   0,32'h0,          0);
    tbl[9]  = mk(0,          0,0,0,  6'h00,0,0,13,0,             0,0,0,          0,32'h8000_0030,  1);
    tbl[10] = mk(32'h3028,   0,1,4,  6'h00,0,0,12,0,             0,0,0,          0,32'h403,        1);
    tbl[11] = mk(0,          0,0,0,  6'h00,1,0,12,0,             0,1,0,          0,32'h403,        1);
    tbl[12] = mk(0,          0,0,0,  6'h00,1,0,14,0,             0,0,0,          0,EPCD,           0);
    tbl[13] = mk(0,          0,0,0,  6'h00,1,0,15,0,             0,0,0,          0,PRID,           0);
    tbl[14] = mk(32'h3050,   0,1,4,  6'h01,0,0,12,0,             1,0,32'h3050,   0,32'h401,        0);
    tbl[15] = mk(0,          0,0,0,  6'h00,0,0,13,0,             0,0,0,          0,32'h400,        1);
    tbl[16] = mk(0,          0,0,0,  6'h00,0,1,12,32'h0000_0401, 0,0,0,          0,32'h403,        1);
    tbl[17] = mk(32'h3060,   0,1,10, 6'h00,0,1,14,32'h0000_3100, 1,0,32'h3060,   0,EPCD,           0);
    tbl[18] = mk(0,          0,0,0,  6'h00,0,1,12,32'h0000_0401, 0,0,0,          0,32'h403,        1);
    tbl[19] = mk(0,          0,0,0,  6'h00,0,1,14,32'h0000_3100, 0,0,0,          1,EPCD,           0);
    tbl[20] = mk(0,          0,0,0,  6'h00,0,1,13,32'hFFFF_FFFF, 0,0,0,          0,32'h28,         0);
    tbl[21] = mk(0,          0,0,0,  6'h00,0,0,13,0,             0,0,0,          0,32'h8000_007C,  0);
    tbl[22] = mk(0,          0,0,0,  6'h00,0,1,12,32'hFFFF_FFFF, 0,0,0,          0,32'h401,        0);
    tbl[23] = mk(0,          0,0,0,  6'h00,0,0,12,0,             0,0,0,          0,32'hFC03,       1);
    tbl[24] = mk(0,          0,0,0,  6'h00,0,1,20,32'h0000_00FF, 0,0,0,          0,32'h0,          1);
    tbl[25] = mk(0,          0,0,0,  6'h00,1,0,12,0,             0,1,0,          0,32'hFC03,       1);
    tbl[26] = mk(0,          0,0,0,  6'h3F,0,0,12,0,             0,0,0,          0,32'hFC01,       0);
    tbl[27] = mk(32'h3070,   0,0,0,  6'h3F,0,0,12,0,             1,0,32'h3070,   0,32'hFC01,       0);

    // Reset state
    idle(12);
    @(negedge clk); #1;
    chk("rst exc_req", {31'b0, exc_req}, 0);
    chk("rst eret_req", {31'b0, eret_req}, 0);
    chk("rst epc_pcwe", {31'b0, epc_pcwe}, 0);
    chk("rst epc_we", {31'b0, epc_we}, 0);
    chk("rst exl", {31'b0, exl}, 0);
    chk("rst SR", cp0_rdata, 0);
    cp0_addr = 13; #1;
    chk("rst Cause", cp0_rdata, 0);
    @(negedge clk); reset = 0;

    // Cycle-by-cycle table
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d exc_req", i), {31'b0, exc_req}, {31'b0, tbl[i].x_exc});
      chk($sformatf("row%0d epc_pcwe", i), {31'b0, epc_pcwe}, {31'b0, tbl[i].x_exc});
      chk($sformatf("row%0d eret_req", i), {31'b0, eret_req}, {31'b0, tbl[i].x_eret});
      chk($sformatf("row%0d epc_we", i), {31'b0, epc_we}, {31'b0, tbl[i].x_we});
      chk($sformatf("row%0d rdata", i), cp0_rdata, tbl[i].x_rd);
      chk($sformatf("row%0d exl", i), {31'b0, exl}, {31'b0, tbl[i].x_exl});
      if (tbl[i].x_exc) chk($sformatf("row%0d epc_pc_in", i), epc_pc_in, tbl[i].x_pcin);
      if (tbl[i].x_we)  chk($sformatf("row%0d epc_din", i), epc_din, tbl[i].wdata);
    end

    // Async reset while in the handler, checked before the next clk edge
    @(negedge clk);
    idle(13); #1;
    chk("pre-rst exl", {31'b0, exl}, 1);
    chk("pre-rst Cause", cp0_rdata, 32'h0000_FC00);
    #1 reset = 1;
    #1;
    chk("async rst exl", {31'b0, exl}, 0);
    chk("async rst Cause", cp0_rdata, 0);
    cp0_addr = 12; #1;
    chk("async rst SR", cp0_rdata, 0);
    @(negedge clk); reset = 0;

`ifdef CP0_TIMER_EN
    mtc0(11, 32'd5);
    mtc0(9, 32'd0);
    mtc0(12, 32'h0000_8001);
    @(negedge clk);
    idle(11); #1;
    chk("timer Compare", cp0_rdata, 32'd5);
    chk("timer early exc_req", {31'b0, exc_req}, 0);
    fired = 0;
    for (int n = 0; n < 20 && !fired; n++) begin
      @(negedge clk);
      idle(9); #1;
      if (exc_req) begin
        fired = 1;
        chk("timer Count at fire", cp0_rdata, 32'd6);
      end
    end
    if (!fired) chk("timer fire timeout", 32'd0, 32'd1);
`else
    fired = 0;
    mtc0(11, 32'd5);
    mtc0(9, 32'd7);
    @(negedge clk);
    idle(9); #1;
    chk("no-timer Count", cp0_rdata, 0);
    cp0_addr = 11; #1;
    chk("no-timer Compare", cp0_rdata, 0);
    chk("no-timer fired", {31'b0, fired}, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
